im_fetch_queue: RTL and testbench
=================================

IM_FETCH_QUEUE -- requirements
Module: im_fetch_queue

Interface
REQ-001 The block SHALL have parameter HVDimension, default 512, hypervector width.
REQ-002 The block SHALL have parameter NumTotIm, default 1024, total item memory entries.
REQ-003 The block SHALL have parameter FifoDepth, default 2, output FIFO entries (power of two, >=2).
REQ-004 The block SHALL have parameter BurstWidth, default 8, burst length field width.
REQ-005 The block SHALL have derived parameter ImAddrWidth = $clog2(NumTotIm).
REQ-006 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-007 clk_i  input  1  rising-edge clock.
REQ-008 rst_i  input  1  synchronous active-high reset.
REQ-009 req_valid_i  input  1  burst request valid.
REQ-010 req_ready_o  output  1  burst request accepted when high with req_valid_i.
REQ-011 req_cim_i  input  1  select CiM for port A for the whole burst.
REQ-012 req_a_addr_i  input  ImAddrWidth  port A start address.
REQ-013 req_b_addr_i  input  ImAddrWidth  port B address, constant over burst.
REQ-014 req_len_i  input  BurstWidth  beats minus one.
REQ-015 im_port_a_cim_o  output  1  to item memory CiM select.
REQ-016 im_a_addr_o, im_b_addr_o  output  ImAddrWidth each  to item memory addresses.
REQ-017 im_a_i, im_b_i  input  HVDimension each  combinational item memory outputs.
REQ-018 out_valid_o  output  1; out_ready_i  input  1  output handshake.
REQ-019 out_a_o, out_b_o  output  HVDimension each; out_last_o  output  1  last beat of burst.
REQ-020 busy_o  output  1  high in FETCH or while FIFO non-empty.

Function
REQ-021 FSM states SHALL be IDLE and FETCH only.
REQ-022 req_ready_o SHALL be 1 in IDLE, 0 in FETCH.
REQ-023 On IDLE accept, the block SHALL register cim, a_addr, b_addr, beat counter = req_len_i and enter FETCH next cycle.
REQ-024 im_* outputs SHALL be driven only from these registers; in IDLE they SHALL hold last values (0 after reset).
REQ-025 In FETCH, a beat SHALL fire when FIFO count < FifoDepth or out_ready_i pops the head this cycle.
REQ-026 A fired beat SHALL push {im_a_i, im_b_i, last = (counter==0)} into the FIFO at that edge.
REQ-027 After a non-last beat, counter SHALL decrement and a_addr SHALL increment by 1 modulo 2^ImAddrWidth; b_addr and cim SHALL hold.
REQ-028 After the last beat, FSM SHALL return to IDLE; next request accepted no earlier than the following cycle.
REQ-029 When a beat cannot fire, all registers SHALL hold (stall, no skipped address).
REQ-030 Latency: first beat at out_valid_o two cycles after the accept edge with empty FIFO and out_ready_i=1.
REQ-031 FIFO SHALL be first-in first-out; out_valid_o = (count != 0); pop on out_valid_o & out_ready_i.
REQ-032 Push into empty FIFO SHALL NOT fall through; data visible the cycle after push.
REQ-033 Simultaneous push and pop at full SHALL be legal, count unchanged, no data loss.
REQ-034 When FIFO empty, out_a_o, out_b_o, out_last_o SHALL be 0.
REQ-035 Output data SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-036 req_len_i = 0 SHALL produce exactly one beat with out_last_o = 1.

Reset
REQ-037 Reset SHALL force IDLE, empty FIFO, counter 0, all address/cim registers 0.
REQ-038 During and one cycle after reset: req_ready_o=1 (after), out_valid_o=0, out data 0, busy_o=0, im_* outputs 0.
REQ-039 Reset mid-burst SHALL discard remaining beats and FIFO contents; no beat SHALL appear afterward.

Verification
REQ-040 Single beat: a_addr=5, b_addr=9, len=0, cim=0, out_ready_i=1 -> one beat = IM[5], IM[9], last=1, two cycles after accept.
REQ-041 Burst: a_addr=1022, len=3, NumTotIm=1024 -> addresses 1022,1023,0,1; last only on 4th beat.
REQ-042 Backpressure: len=7, out_ready_i=0 -> exactly FifoDepth beats buffered, im_a_addr_o frozen; release -> remaining beats in order, none lost or duplicated.
REQ-043 Full push+pop: FIFO full, out_ready_i=1 continuously -> one beat per cycle, count stays FifoDepth.
REQ-044 CiM burst: cim=1, a_addr=3, len=1 -> im_port_a_cim_o=1 whole burst, addresses 3,4.
REQ-045 Reset mid-burst after 2 of 6 beats -> next cycle out_valid_o=0, req_ready_o=1, im addresses 0.

Source files
------------

// File: rtl/im_fetch_queue.sv
// Item-memory burst fetcher with a small output FIFO.
// A burst request walks port A through consecutive addresses while port B
// stays fixed. Each beat captures both item-memory words into the FIFO, and
// the beat stalls whenever the FIFO has no room.
module im_fetch_queue #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned NumTotIm    = 1024,
  parameter int unsigned FifoDepth   = 2,
  parameter int unsigned BurstWidth  = 8,
  parameter int unsigned ImAddrWidth = $clog2(NumTotIm)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_cim_i,
  input  logic [ImAddrWidth-1:0] req_a_addr_i,
  input  logic [ImAddrWidth-1:0] req_b_addr_i,
  input  logic [BurstWidth-1:0]  req_len_i,
  output logic                   im_port_a_cim_o,
  output logic [ImAddrWidth-1:0] im_a_addr_o,
  output logic [ImAddrWidth-1:0] im_b_addr_o,
  input  logic [HVDimension-1:0] im_a_i,
  input  logic [HVDimension-1:0] im_b_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [HVDimension-1:0] out_a_o,
  output logic [HVDimension-1:0] out_b_o,
  output logic                   out_last_o,
  output logic                   busy_o
);

  localparam int unsigned PtrWidth   = $clog2(FifoDepth);
  localparam int unsigned CntWidth   = PtrWidth + 1;
  localparam int unsigned EntryWidth = 2 * HVDimension + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e                 state_r;
  logic                   cim_r;
  logic [ImAddrWidth-1:0] a_addr_r;
  logic [ImAddrWidth-1:0] b_addr_r;
  logic [BurstWidth-1:0]  beat_cnt_r;

  logic [EntryWidth-1:0]  fifo_mem_r [FifoDepth];
  logic [PtrWidth-1:0]    rd_ptr_r;
  logic [PtrWidth-1:0]    wr_ptr_r;
  logic [CntWidth-1:0]    fifo_cnt_r;

  logic                   accept_s;
  logic                   pop_s;
  logic                   fire_s;
  logic                   last_s;
  logic                   nonempty_s;
  logic [EntryWidth-1:0]  head_s;

  // Handshake decode. A beat may fire into a full FIFO when the head leaves
  // on the same edge, so a continuously drained queue runs at one beat per cycle.
  always_comb begin
    nonempty_s = (fifo_cnt_r != CntWidth'(0));
    accept_s   = (state_r == IDLE) && req_valid_i;
    pop_s      = nonempty_s && out_ready_i;
    fire_s     = (state_r == FETCH) && ((fifo_cnt_r < CntWidth'(FifoDepth)) || pop_s);
    last_s     = (beat_cnt_r == BurstWidth'(0));
    head_s     = fifo_mem_r[rd_ptr_r];
  end

  // Burst sequencer: load the request, then step port A one address per fired beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      cim_r      <= 1'b0;
      a_addr_r   <= '0;
      b_addr_r   <= '0;
      beat_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cim_r      <= req_cim_i;
            a_addr_r   <= req_a_addr_i;
            b_addr_r   <= req_b_addr_i;
            beat_cnt_r <= req_len_i;
            state_r    <= FETCH;
          end
        end
        FETCH: begin
          if (fire_s) begin
            if (last_s) begin
              state_r <= IDLE;
            end else begin
              beat_cnt_r <= beat_cnt_r - BurstWidth'(1);
              a_addr_r   <= a_addr_r + ImAddrWidth'(1);
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Output FIFO: capture item-memory words on fire, advance the head on pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (fire_s) begin
        fifo_mem_r[wr_ptr_r] <= {im_a_i, im_b_i, last_s};
        wr_ptr_r             <= wr_ptr_r + PtrWidth'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrWidth'(1);
      end
      case ({fire_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CntWidth'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CntWidth'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Output drive. Data is forced to zero while empty, so stale entries are never visible.
  always_comb begin
    req_ready_o     = (state_r == IDLE);
    im_port_a_cim_o = cim_r;
    im_a_addr_o     = a_addr_r;
    im_b_addr_o     = b_addr_r;
    out_valid_o     = nonempty_s;
    busy_o          = (state_r == FETCH) || nonempty_s;
    if (nonempty_s) begin
      out_a_o    = head_s[EntryWidth-1 -: HVDimension];
      out_b_o    = head_s[HVDimension -: HVDimension];
      out_last_o = head_s[0];
    end else begin
      out_a_o    = '0;
      out_b_o    = '0;
      out_last_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_im_fetch_queue.sv
// Directed bench for im_fetch_queue with a combinational item-memory model.
module tb_im_fetch_queue;

  localparam int HV = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_cim_i = 1'b0;
  logic [AW-1:0] req_a_addr_i = '0;
  logic [AW-1:0] req_b_addr_i = '0;
  logic [7:0]    req_len_i = '0;
  logic          im_port_a_cim_o;
  logic [AW-1:0] im_a_addr_o;
  logic [AW-1:0] im_b_addr_o;
  logic [HV-1:0] im_a_i;
  logic [HV-1:0] im_b_i;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [HV-1:0] out_a_o;
  logic [HV-1:0] out_b_o;
  logic          out_last_o;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [HV*2:0] beats [$];

  im_fetch_queue #(
    .HVDimension(HV), .NumTotIm(1024), .FifoDepth(2), .BurstWidth(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_cim_i(req_cim_i), .req_a_addr_i(req_a_addr_i),
    .req_b_addr_i(req_b_addr_i), .req_len_i(req_len_i),
    .im_port_a_cim_o(im_port_a_cim_o),
    .im_a_addr_o(im_a_addr_o), .im_b_addr_o(im_b_addr_o),
    .im_a_i(im_a_i), .im_b_i(im_b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_a_o(out_a_o), .out_b_o(out_b_o), .out_last_o(out_last_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Item-memory word: tag byte per port, CiM flag, address in the low bits.
  function automatic logic [HV-1:0] im_val(input logic [AW-1:0] addr, input logic port_b,
                                          input logic cim);
    return {(port_b ? 8'hB0 : 8'hA0), 7'd0, cim, 6'd0, addr};
  endfunction

  assign im_a_i = im_val(im_a_addr_o, 1'b0, im_port_a_cim_o);
  assign im_b_i = im_val(im_b_addr_o, 1'b1, 1'b0);

  // Record every beat that leaves through the output handshake.
  always @(negedge clk) begin
    if (!rst_i && out_valid_o && out_ready_i) beats.push_back({out_a_o, out_b_o, out_last_o});
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, then drop valid right after the accept edge.
  task automatic send_req(input logic cim, input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [7:0] len);
    step();
    req_cim_i    = cim;
    req_a_addr_i = a;
    req_b_addr_i = b;
    req_len_i    = len;
    req_valid_i  = 1'b1;
    @(negedge clk);
    check_eq("req_ready_idle", req_ready_o, 1'b1);
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic check_burst(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] b,
                             input logic cim, input int n);
    logic [AW-1:0] a;
    check_eq({tag, "_count"}, beats.size(), n);
    for (int i = 0; i < n && i < beats.size(); i++) begin
      a = a0 + AW'(i);
      check_eq($sformatf("%s_beat%0d", tag, i), beats[i],
               {im_val(a, 1'b0, cim), im_val(b, 1'b1, 1'b0), (i == n - 1)});
    end
  endtask

  initial begin
    int n_valid;

    // Reset state
    step();
    @(negedge clk);
    check_eq("rst_out_valid", out_valid_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_im_a_addr", im_a_addr_o, 10'd0);
    check_eq("rst_out_a", out_a_o, 32'd0);
    step();
    rst_i = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", req_ready_o, 1'b1);
    check_eq("post_rst_valid", out_valid_o, 1'b0);
    check_eq("post_rst_busy", busy_o, 1'b0);
    check_eq("post_rst_im_b", im_b_addr_o, 10'd0);
    check_eq("post_rst_cim", im_port_a_cim_o, 1'b0);

    // Single beat, len=0: data two cycles after request
    beats.delete();
    out_ready_i = 1'b1;
    send_req(1'b0, 10'd5, 10'd9, 8'd0);
    @(negedge clk);
    check_eq("single_no_fallthru", out_valid_o, 1'b0);
    check_eq("single_ready_fetch", req_ready_o, 1'b0);
    check_eq("single_im_a", im_a_addr_o, 10'd5);
    check_eq("single_im_b", im_b_addr_o, 10'd9);
    check_eq("single_busy", busy_o, 1'b1);
    step();
    @(negedge clk);
    check_eq("single_valid", out_valid_o, 1'b1);
    check_eq("single_out_a", out_a_o, im_val(10'd5, 1'b0, 1'b0));
    check_eq("single_out_b", out_b_o, im_val(10'd9, 1'b1, 1'b0));
    check_eq("single_last", out_last_o, 1'b1);
    step();
    @(negedge clk);
    check_eq("single_drained", out_valid_o, 1'b0);
    check_eq("single_empty_data", out_a_o, 32'd0);
    check_eq("single_idle_busy", busy_o, 1'b0);
    check_eq("single_idle_hold", im_a_addr_o, 10'd5);
    check_eq("single_count", beats.size(), 1);

    // Address wrap at the top of the item memory
    beats.delete();
    send_req(1'b0, 10'd1022, 10'd7, 8'd3);
    wait_idle("wrap");
    check_burst("wrap", 10'd1022, 10'd7, 1'b0, 4);

    // Backpressure: two beats buffered, port A frozen, then full-rate drain
    beats.delete();
    out_ready_i = 1'b0;
    send_req(1'b0, 10'd100, 10'd3, 8'd7);
    repeat (5) step();
    @(negedge clk);
    check_eq("bp_addr_frozen", im_a_addr_o, 10'd102);
    check_eq("bp_valid", out_valid_o, 1'b1);
    check_eq("bp_head", out_a_o, im_val(10'd100, 1'b0, 1'b0));
    check_eq("bp_no_pop", beats.size(), 0);
    step();
    @(negedge clk);
    check_eq("bp_addr_still", im_a_addr_o, 10'd102);
    check_eq("bp_head_stable", out_a_o, im_val(10'd100, 1'b0, 1'b0));
    step();
    out_ready_i = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid_o) break;
      n_valid++;
    end
    check_eq("bp_full_rate", n_valid, 8);
    wait_idle("bp");
    check_burst("bp", 10'd100, 10'd3, 1'b0, 8);

    // CiM burst
    beats.delete();
    send_req(1'b1, 10'd3, 10'd11, 8'd1);
    @(negedge clk);
    check_eq("cim_sel0", im_port_a_cim_o, 1'b1);
    check_eq("cim_addr0", im_a_addr_o, 10'd3);
    step();
    @(negedge clk);
    check_eq("cim_sel1", im_port_a_cim_o, 1'b1);
    check_eq("cim_addr1", im_a_addr_o, 10'd4);
    wait_idle("cim");
    check_burst("cim", 10'd3, 10'd11, 1'b1, 2);

    // Reset after two of six beats
    beats.delete();
    send_req(1'b0, 10'd200, 10'd20, 8'd5);
    step();
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", out_valid_o, 1'b0);
    check_eq("mid_rst_ready", req_ready_o, 1'b1);
    check_eq("mid_rst_im_a", im_a_addr_o, 10'd0);
    check_eq("mid_rst_im_b", im_b_addr_o, 10'd0);
    check_eq("mid_rst_out_a", out_a_o, 32'd0);
    check_eq("mid_rst_busy", busy_o, 1'b0);
    beats.delete();
    repeat (10) @(negedge clk);
    check_eq("mid_rst_no_beats", beats.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
